// File: rtl/width_split.sv
// Wide-to-narrow splitter: emits one captured wide word as MSB-first narrow beats.
// Optional rd_align_last output enabled by defining WIDTH_SPLIT_ALIGN_LAST_EN.
module width_split #(
    parameter int DSIZE = 1,
    parameter int NSIZE = 8,
    localparam int RSIZE = (NSIZE < 16)  ? 4 :
                           (NSIZE < 32)  ? 5 :
                           (NSIZE < 64)  ? 6 :
                           (NSIZE < 128) ? 7 : 8
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [DSIZE*NSIZE-1:0] wr_data,
    input  logic                   wr_vld,
    output logic                   wr_ready,
    input  logic                   wr_last,
    input  logic [RSIZE-1:0]       wr_cnt,
    output logic [DSIZE-1:0]       rd_data,
    output logic                   rd_vld,
    input  logic                   rd_ready,
    output logic                   rd_last,
    output logic                   rd_align_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [RSIZE-1:0] MAX_CNT = RSIZE'(NSIZE - 1);

    state_t                 state_q, state_d;
    logic [DSIZE*NSIZE-1:0] hold_q,  hold_d;
    logic                   last_q,  last_d;
    logic [RSIZE-1:0]       cnt_q,   cnt_d;
    logic [RSIZE-1:0]       ptr_q,   ptr_d;

    logic             atFinal;
    logic             wrAcc;
    logic             rdAcc;
    logic [RSIZE-1:0] cntClamped;

    assign atFinal    = (ptr_q == cnt_q);
    assign rd_vld     = (state_q == SEND);
    assign wr_ready   = (state_q == IDLE) || (atFinal && rd_ready);
    assign wrAcc      = wr_vld && wr_ready;
    assign rdAcc      = rd_vld && rd_ready;
    assign cntClamped = (wr_cnt > MAX_CNT) ? MAX_CNT : wr_cnt;
    assign rd_last    = rd_vld && atFinal && last_q;

`ifdef WIDTH_SPLIT_ALIGN_LAST_EN
    assign rd_align_last = rd_vld && atFinal;
`else
    assign rd_align_last = 1'b0;
`endif

    // Beat selection uses constant slices so rd_data is a pure mux of hold bits.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NSIZE; i++) begin
            if (ptr_q == RSIZE'(i)) begin
                rd_data = hold_q[DSIZE*(NSIZE-i)-1 -: DSIZE];
            end
        end
    end

    // A wide accept in SEND only happens on the final-beat accept, so it takes priority.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (wrAcc) begin
            state_d = SEND;
            hold_d  = wr_data;
            last_d  = wr_last;
            cnt_d   = cntClamped;
            ptr_d   = '0;
        end else if (rdAcc) begin
            if (atFinal) begin
                state_d = IDLE;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
